// File: rtl/seq_mult32_if.sv
// Operand/result handshake bundle between the operand-entry stage,
// the shift-add multiplier and the display/result stage.
interface seq_mult32_if #(
  parameter int unsigned WIDTH = 32
) ();

  // Operand side: valid/ready handshake carrying the A/B pair and mode
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               signed_mode;

  // Result side: product held until the consumer takes it
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;

  // Status
  logic               busy;

  // Upstream/downstream agent view: drives operands and out_ready
  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output signed_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  busy
  );

  // Multiplier view
  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  signed_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output busy
  );

endinterface

// File: rtl/seq_mult32.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock on operand
// magnitudes, sign applied in a final step, result held until consumed.
module seq_mult32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_mult32_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;        // product width
  localparam int unsigned AW = PW + 1;           // accumulator keeps the add carry
  localparam int unsigned CW = $clog2(WIDTH + 1); // bit counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    result_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_d;
  logic             out_valid_d;
  logic             busy_d;

  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic             neg_in_c;
  logic             last_c;
  logic [WIDTH:0]   addend_c;
  logic [WIDTH:0]   upper_c;
  logic [AW-1:0]    acc_step_c;
  logic [PW-1:0]    prod_neg_c;

  // Operand magnitudes and one shift-add step of the accumulator
  always_comb begin
    abs_a_c    = bus.op_a;
    abs_b_c    = bus.op_b;
    neg_in_c   = bus.signed_mode & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
    // -2^(WIDTH-1) negates to itself, which read unsigned is its magnitude
    if (bus.signed_mode && bus.op_a[WIDTH-1]) abs_a_c = ~bus.op_a + WIDTH'(1);
    if (bus.signed_mode && bus.op_b[WIDTH-1]) abs_b_c = ~bus.op_b + WIDTH'(1);
    last_c     = (cnt == CW'(WIDTH - 1));
    addend_c   = mag_b[0] ? {1'b0, mag_a} : '0;
    upper_c    = acc[AW-1:WIDTH] + addend_c;
    acc_step_c = {upper_c, acc[WIDTH-1:0]} >> 1;
    prod_neg_c = ~acc[PW-1:0] + PW'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.in_valid)  state_next = S_RUN;
      S_RUN:   if (last_c)        state_next = S_SIGN;
      S_SIGN:                     state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register with it
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_next)
      S_IDLE:  in_ready_d  = 1'b1;
      S_RUN:   busy_d      = 1'b1;
      S_SIGN:  busy_d      = 1'b1;
      S_DONE:  out_valid_d = 1'b1;
      default: in_ready_d  = 1'b0;
    endcase
  end

  // Status output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Datapath: capture at accept, shift-add in RUN, apply sign in SIGN
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a    <= '0;
      mag_b    <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mag_a <= abs_a_c;
            mag_b <= abs_b_c;
            neg   <= neg_in_c;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          acc   <= acc_step_c;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + CW'(1);
        end
        S_SIGN: begin
          result_q <= neg ? prod_neg_c : acc[PW-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

endmodule
